// File: rtl/way_encoder_pkg.sv
// way_encoder_pkg: cache geometry constants and the encoded-result entry type
// shared by the way encoder and its priority-encoder sub-module.
package way_encoder_pkg;

    // Default and maximum cache associativity.
    localparam int WAYS_DEF  = 4;
    localparam int WAYS_MAX  = 16;

    // Encoded index widths: default geometry and the widest supported geometry.
    localparam int IDX_W_DEF = $clog2(WAYS_DEF);
    localparam int IDX_MAX_W = $clog2(WAYS_MAX);

    // Default statistics counter width.
    localparam int CNT_W_DEF = 16;

    // Output buffer depth (head + skid).
    localparam int BUF_DEPTH = 2;

    // One buffer entry. The index field is sized for the widest geometry;
    // narrower configurations zero-extend and only expose the low bits.
    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic                 hit;
        logic                 multi;
    } enc_t;

endpackage

// File: rtl/way_encoder_prienc.sv
// onehot_prienc: purely combinational LSB-priority encoder for a per-way hit
// vector. Produces the lowest hitting way index, an any-hit flag and a
// more-than-one-hit flag. An all-zero vector encodes as idx=0, hit=0, multi=0.
module onehot_prienc
    import way_encoder_pkg::*;
#(
    parameter int WAYS = WAYS_DEF
) (
    input  logic [WAYS-1:0] hit_vec_i,
    output enc_t            enc_o
);

    logic [IDX_MAX_W-1:0] idx_d;
    logic                 found_d;
    logic                 multi_d;

    // Scan from way 0 upward: the first set bit wins, any later set bit flags a multi-hit.
    always_comb begin
        idx_d   = '0;
        found_d = 1'b0;
        multi_d = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec_i[i]) begin
                if (found_d) begin
                    multi_d = 1'b1;
                end else begin
                    idx_d   = IDX_MAX_W'(i);
                    found_d = 1'b1;
                end
            end
        end
    end

    assign enc_o.idx   = idx_d;
    assign enc_o.hit   = found_d;
    assign enc_o.multi = multi_d;

endmodule

// File: rtl/way_encoder.sv
// way_encoder: encodes a one-hot cache hit vector into a binary way index plus
// hit / multi-hit flags, behind valid/ready handshakes with a 2-entry
// (head + skid) output buffer.
// Optional feature macro: WAYENC_STATS_EN enables saturating hit/miss
// counters; without it hitCount/missCount are tied to 0 and no counter flops exist.
module way_encoder
    import way_encoder_pkg::*;
#(
    parameter  int WAYS  = WAYS_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int IDX_W = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WAYS-1:0]   hitIn,
    input  logic              inValid,
    output logic              inReady,
    output logic [IDX_W-1:0]  encOut,
    output logic              hitOut,
    output logic              multiHit,
    output logic              outValid,
    input  logic              outReady,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  missCount
);

    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    enc_t       enc_new;
    enc_t       head_q, head_d;
    enc_t       skid_q, skid_d;
    logic [1:0] count_q, count_d;
    logic       accept;
    logic       pop;

    onehot_prienc #(
        .WAYS (WAYS)
    ) u_prienc (
        .hit_vec_i (hitIn),
        .enc_o     (enc_new)
    );

    assign inReady  = (count_q < FULL_CNT);
    assign outValid = (count_q != 2'd0);
    assign accept   = inValid && inReady;
    assign pop      = outValid && outReady;

    // Buffer next state: head always holds the oldest entry, skid the second.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    head_d  = enc_new;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && pop) begin
                    head_d = enc_new;
                end else if (accept) begin
                    skid_d  = enc_new;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: no accept is possible here since inReady is low.
                if (pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    // Buffer registers; reset discards all entries and zeroes the head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign encOut   = head_q.idx[IDX_W-1:0];
    assign hitOut   = head_q.hit;
    assign multiHit = head_q.multi;

    // Index bits above IDX_W are always zero for narrower geometries.
    logic unused_idx_hi;
    assign unused_idx_hi = ^head_q.idx;

`ifdef WAYENC_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Count each accepted lookup as a hit or a miss, saturating at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept) begin
            if (enc_new.hit) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_way_encoder.sv
// tb_way_encoder: self-checking bench for way_encoder (WAYS=4, CNT_W=4).
// Expected encodings come from a behavioural model pushed into a queue on
// each accepted lookup and compared whenever the DUT pops an entry.
module tb_way_encoder;

    typedef struct packed {
        logic [1:0] idx;
        logic       hit;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] hitIn;
    logic       inValid;
    logic       inReady;
    logic [1:0] encOut;
    logic       hitOut;
    logic       multiHit;
    logic       outValid;
    logic       outReady;
    logic [3:0] hitCount;
    logic [3:0] missCount;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    int   exp_hit  = 0;
    int   exp_miss = 0;

    way_encoder #(
        .WAYS  (4),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hitIn     (hitIn),
        .inValid   (inValid),
        .inReady   (inReady),
        .encOut    (encOut),
        .hitOut    (hitOut),
        .multiHit  (multiHit),
        .outValid  (outValid),
        .outReady  (outReady),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lowest set bit, any-set, more-than-one-set.
    function automatic exp_t model_enc(input logic [3:0] h);
        exp_t       r;
        logic [3:0] low;
        low     = h & (~h + 4'd1);
        r.idx   = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
        r.hit   = (h != 4'd0);
        r.multi = ($countones(h) > 1);
        return r;
    endfunction

    // Required counter value for the current build.
    function automatic logic [3:0] stat_req(input int v);
`ifdef WAYENC_STATS_EN
        return (v > 15) ? 4'd15 : 4'(v);
`else
        return (v > 0) ? 4'd0 : 4'd0;
`endif
    endfunction

    // Scoreboard monitor: compare each popped head against the queue, queue each accept.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (outValid && outReady) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_pop: DUT output idx=%0d hit=%0d multi=%0d, required no output (queue empty)",
                             encOut, hitOut, multiHit);
                end else begin
                    e = sb_q.pop_front();
                    if ({encOut, hitOut, multiHit} !== {e.idx, e.hit, e.multi}) begin
                        bad++;
                        $display("FAIL sb_pop: got idx=%0d hit=%0d multi=%0d, required idx=%0d hit=%0d multi=%0d",
                                 encOut, hitOut, multiHit, e.idx, e.hit, e.multi);
                    end
                end
            end
            if (inValid && inReady) begin
                e = model_enc(hitIn);
                sb_q.push_back(e);
                if (e.hit) exp_hit++;
                else       exp_miss++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Offer one lookup and hold it until accepted (bounded); returns at posedge+1.
    task automatic push_one(input logic [3:0] h);
        int n;
        n       = 0;
        hitIn   = h;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL push_timeout: inReady stayed %0d, required 1", inReady);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Wait (bounded) until every queued entry has been popped.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || outValid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL drain_timeout: %0d entries left, required 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        inValid  = 1'b1;
        hitIn    = 4'b0100;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({inReady, outValid, encOut, hitOut, multiHit} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs: inReady=%0d outValid=%0d enc=%0d hit=%0d multi=%0d, required 1 0 0 0 0",
                     inReady, outValid, encOut, hitOut, multiHit);
        end
        total++;
        if (hitCount !== 4'd0 || missCount !== 4'd0) begin
            bad++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hitCount, missCount);
        end
        #2;
        inValid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_transfer: outValid=%0d, required 0", outValid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        outReady = 1'b1;
        push_one(4'b0100);
        @(negedge clk);
        total++;
        if ({outValid, encOut, hitOut, multiHit} !== {1'b1, 2'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_hit: valid=%0d idx=%0d hit=%0d multi=%0d, required 1 2 1 0",
                     outValid, encOut, hitOut, multiHit);
        end
        @(negedge clk);
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL single_after: outValid=%0d, required 0", outValid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_miss();
        push_one(4'b0000);
        @(negedge clk);
        total++;
        if ({outValid, encOut, hitOut, multiHit} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL miss_enc: valid=%0d idx=%0d hit=%0d multi=%0d, required 1 0 0 0",
                     outValid, encOut, hitOut, multiHit);
        end
        total++;
        if (missCount !== stat_req(1) || hitCount !== stat_req(1)) begin
            bad++;
            $display("FAIL miss_count: hit=%0d miss=%0d, required %0d %0d",
                     hitCount, missCount, stat_req(1), stat_req(1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multi();
        push_one(4'b1010);
        @(negedge clk);
        total++;
        if ({outValid, encOut, hitOut, multiHit} !== {1'b1, 2'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL multi_hit: valid=%0d idx=%0d hit=%0d multi=%0d, required 1 1 1 1",
                     outValid, encOut, hitOut, multiHit);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        push_one(4'b0001);
        push_one(4'b1000);
        @(negedge clk);
        total++;
        if (inReady !== 1'b0 || outValid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: inReady=%0d outValid=%0d, required 0 1", inReady, outValid);
        end
        hitIn   = 4'b0010;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (inReady !== 1'b0 || encOut !== 2'd0 || hitOut !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: inReady=%0d idx=%0d hit=%0d, required 0 0 1", inReady, encOut, hitOut);
            end
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
        push_one(4'b0010);
        drain();
    endtask

    task automatic test_stream();
        outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hitIn   = 4'(i);
            inValid = 1'b1;
            @(negedge clk);
            total++;
            if (inReady !== 1'b1 || (i > 0 && outValid !== 1'b1)) begin
                bad++;
                $display("FAIL stream_bubble: step=%0d inReady=%0d outValid=%0d, required 1 1", i, inReady, outValid);
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        @(negedge clk);
        total++;
        if (outValid !== 1'b1 || encOut !== 2'd0 || multiHit !== 1'b1) begin
            bad++;
            $display("FAIL stream_last: valid=%0d idx=%0d multi=%0d, required 1 0 1", outValid, encOut, multiHit);
        end
        drain();
    endtask

    task automatic test_saturate_and_reset();
        // Fresh counters.
        rst_n = 1'b0;
        sb_q.delete();
        exp_hit  = 0;
        exp_miss = 0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        hitIn    = 4'b0001;
        inValid  = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (hitCount !== stat_req(20) || missCount !== 4'd0) begin
            bad++;
            $display("FAIL sat_count: hit=%0d miss=%0d, required %0d 0", hitCount, missCount, stat_req(20));
        end
        // Mid-stream asynchronous reset.
        @(posedge clk);
        #1;
        outReady = 1'b0;
        hitIn    = 4'b0110;
        inValid  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (outValid !== 1'b0 || hitCount !== 4'd0 || missCount !== 4'd0 || inReady !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: valid=%0d hit=%0d miss=%0d inReady=%0d, required 0 0 0 1",
                     outValid, hitCount, missCount, inReady);
        end
        sb_q.delete();
        exp_hit  = 0;
        exp_miss = 0;
        inValid  = 1'b0;
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        total++;
        if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: outValid=%0d, required 0", outValid);
        end
    endtask

    // Test sequence.
    initial begin
        rst_n    = 1'b0;
        hitIn    = 4'b0000;
        inValid  = 1'b0;
        outReady = 1'b0;
        test_reset();
        test_single();
        test_miss();
        test_multi();
        test_backpressure();
        test_stream();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
